// File: rtl/wm8731_init_seq.sv
// WM8731 register init sequencer: walks a fixed 12-word table and hands each word to the
// control-port serializer. Define WM8731_TIMEOUT_EN to add a per-word cmd_done watchdog and err.
module wm8731_init_seq #(
  parameter int unsigned GAP_CYCLES       = 500,
  parameter int unsigned RESET_GAP_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES   = 2000000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        start,
  output logic        cmd_valid,
  output logic [15:0] cmd_data,
  input  logic        cmd_done,
  output logic        busy,
  output logic        init_done,
`ifdef WM8731_TIMEOUT_EN
  output logic        err,
`endif
  output logic [3:0]  idx
);

  localparam logic [3:0]  LastIdx   = 4'd11;
  localparam logic [23:0] GapLim    = 24'(GAP_CYCLES - 1);
  localparam logic [23:0] RstGapLim = 24'(RESET_GAP_CYCLES - 1);

`ifdef WM8731_TIMEOUT_EN
  localparam logic [23:0] TimeoutLim = 24'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {StIdle, StLoad, StSend, StGap, StDone, StErr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StSend, StGap, StDone} state_e;
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] rom_word;
  logic [23:0] gap_lim;

  always_comb begin
    unique case (idx_q)
      4'd0:    rom_word = 16'h1E00;
      4'd1:    rom_word = 16'h0C10;
      4'd2:    rom_word = 16'h0017;
      4'd3:    rom_word = 16'h0217;
      4'd4:    rom_word = 16'h0479;
      4'd5:    rom_word = 16'h0679;
      4'd6:    rom_word = 16'h0812;
      4'd7:    rom_word = 16'h0A00;
      4'd8:    rom_word = 16'h0E02;
      4'd9:    rom_word = 16'h1000;
      4'd10:   rom_word = 16'h1201;
      4'd11:   rom_word = 16'h0C00;
      default: rom_word = 16'h0000;
    endcase
  end

  // The reset register needs the codec to settle before the next write.
  assign gap_lim = (idx_q == 4'd0) ? RstGapLim : GapLim;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          idx_d   = 4'd0;
        end
      end
      StLoad: begin
        data_d  = rom_word;
        cnt_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (cmd_done) begin
          cnt_d   = '0;
          state_d = StGap;
        end
`ifdef WM8731_TIMEOUT_EN
        else if (cnt_q == TimeoutLim) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
`endif
      end
      StGap: begin
        if (cnt_q == gap_lim) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StLoad;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
`ifdef WM8731_TIMEOUT_EN
      StErr: begin
        if (start) begin
          state_d = StLoad;
          idx_d   = 4'd0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_valid = (state_q == StSend);
  assign cmd_data  = data_q;
  assign busy      = (state_q == StLoad) || (state_q == StSend) || (state_q == StGap);
  assign init_done = (state_q == StDone);
  assign idx       = idx_q;
`ifdef WM8731_TIMEOUT_EN
  assign err       = (state_q == StErr);
`endif

endmodule
